// File: rtl/stream_fifo.sv
// Synchronous valid/ready FIFO with occupancy count, almost-full/empty flags and flush.
// Optional STREAM_FIFO_WATERMARK_EN adds a peak-occupancy register with peak_clr/peak ports.
module stream_fifo #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned AFULL_TH  = (1 << ADDR_W) - 1,
    parameter int unsigned AEMPTY_TH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W:0]   count,
`ifdef STREAM_FIFO_WATERMARK_EN
    input  logic              peak_clr,
    output logic [ADDR_W:0]   peak,
`endif
    output logic              almost_full,
    output logic              almost_empty
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FullCount   = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] AfullCount  = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] AemptyCount = AEMPTY_TH[ADDR_W:0];

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              push, pop;

    // Handshake flags come from registered count only: no out_ready -> in_ready path.
    assign in_ready     = (count_q != FullCount);
    assign out_valid    = (count_q != '0);
    assign out_data     = mem_q[rd_ptr_q];
    assign count        = count_q;
    assign almost_full  = (count_q >= AfullCount);
    assign almost_empty = (count_q <= AemptyCount);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; a flushed push is simply not written.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef STREAM_FIFO_WATERMARK_EN
    logic [ADDR_W:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (peak_clr) begin
            peak_d = count_q;
        end else if (count_q > peak_q) begin
            peak_d = count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Directed self-checking bench for stream_fifo (DEPTH=8); covers watermark when
// STREAM_FIFO_WATERMARK_EN is defined.
module tb_stream_fifo;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [3:0] count;
    logic       almost_full, almost_empty;
`ifdef STREAM_FIFO_WATERMARK_EN
    logic       peak_clr;
    logic [3:0] peak;
`endif

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    stream_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .count        (count),
`ifdef STREAM_FIFO_WATERMARK_EN
        .peak_clr     (peak_clr),
        .peak         (peak),
`endif
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
`ifdef STREAM_FIFO_WATERMARK_EN
        peak_clr  = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_afull", 32'(almost_full), 32'd0);
        check_eq("rst_aempty", 32'(almost_empty), 32'd1);

        // Fill to full.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h10 + i);
            step();
            check_eq("fill_count", 32'(count), 32'(i + 1));
            check_eq("fill_afull", 32'(almost_full), 32'(i + 1 >= 7));
        end
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        in_data = 8'h18;
        step();
        check_eq("ninth_count", 32'(count), 32'd8);
        check_eq("ninth_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // Drain from full.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("drain_valid", 32'(out_valid), 32'd1);
            check_eq("drain_data", 32'(out_data), 32'(8'h10 + i));
            step();
            check_eq("drain_count", 32'(count), 32'(7 - i));
            check_eq("drain_aempty", 32'(almost_empty), 32'(7 - i <= 1));
        end
        check_eq("drained_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // First-word fall-through latency.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        check_eq("push_cycle_valid", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        check_eq("fwft_valid", 32'(out_valid), 32'd1);
        check_eq("fwft_data", 32'(out_data), 32'h0A5);
        check_eq("fwft_count", 32'(count), 32'd1);
        exp_q.push_back(8'hA5);

        // Reach count=4, then stream through the pointer wrap.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h20 + i);
            exp_q.push_back(in_data);
            step();
        end
        check_eq("hold_start_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 8'(8'h40 + i);
            check_eq("stream_data", 32'(out_data), 32'(exp_q.pop_front()));
            exp_q.push_back(in_data);
            step();
            check_eq("stream_count", 32'(count), 32'd4);
        end

        // Refill to full, then offer push and pop together.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(8'h50 + i);
            exp_q.push_back(in_data);
            step();
        end
        check_eq("refull_count", 32'(count), 32'd8);
        in_data   = 8'h60;
        out_ready = 1'b1;
        check_eq("full_pp_data", 32'(out_data), 32'(exp_q.pop_front()));
        step();
        in_valid = 1'b0;
        check_eq("full_pp_count", 32'(count), 32'd7);
        check_eq("full_pp_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 7; i++) begin
            check_eq("tail_data", 32'(out_data), 32'(exp_q.pop_front()));
            step();
        end
        check_eq("tail_empty_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Flush beats a simultaneous push and pop.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h70 + i);
            step();
        end
        check_eq("preflush_count", 32'(count), 32'd5);
        flush     = 1'b1;
        in_data   = 8'h33;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("flush_count", 32'(count), 32'd0);
        check_eq("flush_out_valid", 32'(out_valid), 32'd0);
        check_eq("flush_in_ready", 32'(in_ready), 32'd1);
        check_eq("flush_aempty", 32'(almost_empty), 32'd1);
        check_eq("flush_afull", 32'(almost_full), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h44;
        step();
        in_valid = 1'b0;
        check_eq("postflush_count", 32'(count), 32'd1);
        check_eq("postflush_data", 32'(out_data), 32'h044);

`ifdef STREAM_FIFO_WATERMARK_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("peak_rst", 32'(peak), 32'd0);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h80 + i);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
        end
        out_ready = 1'b0;
        check_eq("peak_count", 32'(count), 32'd2);
        check_eq("peak_max", 32'(peak), 32'd6);
        peak_clr = 1'b1;
        step();
        peak_clr = 1'b0;
        check_eq("peak_clr", 32'(peak), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("peak_rst2", 32'(peak), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
